cpu_axi_bridge: RTL and testbench

Bridge that shares one AXI3-subset master port between the CPU's instruction fetch port and data memory port, both speaking the SRAM-like request/addr_ok/data_ok protocol. It arbitrates reads between the two requesters and sequences AR/R and AW/W/B channel handshakes. It sits between the pipeline's fetch/memory stages and the SoC AXI interconnect. AXI fields not listed below (len=0, burst=INCR, lock, cache, prot) are constants tied off in the SoC wrapper.

---
 rtl/cpu_axi_bridge_if.sv | 51 +++++
 rtl/cpu_axi_bridge.sv | 110 +++++++++++
 tb/tb_cpu_axi_bridge.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: SRAM-like inst/data ports plus the shared AXI3-subset master channels.
// master = bridge side, slave = CPU pipeline plus AXI interconnect side.
interface cpu_axi_bridge_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  arready, rid, rdata, rvalid, awready, wready, bvalid,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output arready, rid, rdata, rvalid, awready, wready, bvalid,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: shares one AXI master between the inst and data SRAM-like ports.
// Define BRIDGE_DATA_PRIO_EN to make data reads always win read arbitration (default: round-robin).
module cpu_axi_bridge (
    input  logic             clk,
    input  logic             resetn,
    cpu_axi_bridge_if.master bus
);
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_AR    = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_SEND  = 2'd1;
    localparam logic [1:0] W_BRESP = 2'd2;

    logic [1:0]  r_state_q, r_state_d, w_state_q, w_state_d;
    logic        rsrc_q, rsrc_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [2:0]  arsize_q, arsize_d, awsize_q, awsize_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic        r_idle, w_idle, inst_elig, data_rd_elig, grant_data, rd_grant, w_accept, r_done;
    logic        unused_rid;

    assign r_idle       = r_state_q == R_IDLE;
    assign w_idle       = w_state_q == W_IDLE;
    assign inst_elig    = bus.inst_req;
    assign data_rd_elig = bus.data_req & ~bus.data_wr & w_idle;
    assign rd_grant     = r_idle & (inst_elig | data_rd_elig);
    // A data write must not start while a data read is still in flight.
    assign w_accept     = w_idle & bus.data_req & bus.data_wr & (r_idle | ~rsrc_q);
    assign r_done       = bus.rvalid & (r_state_q == R_WAIT);
    assign unused_rid   = ^bus.rid;

`ifdef BRIDGE_DATA_PRIO_EN
    assign grant_data = data_rd_elig;
`else
    logic prefer_data_q, prefer_data_d;
    assign grant_data    = data_rd_elig & (~inst_elig | prefer_data_q);
    assign prefer_data_d = rd_grant ? ~grant_data : prefer_data_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prefer_data_q <= 1'b0;
        else         prefer_data_q <= prefer_data_d;
    end
`endif

    always_comb begin
        r_state_d = r_idle ? (rd_grant ? R_AR : R_IDLE) :
                    (r_state_q == R_AR) ? (bus.arready ? R_WAIT : R_AR) :
                    (r_state_q == R_WAIT) ? (bus.rvalid ? R_IDLE : R_WAIT) : R_IDLE;
        rsrc_d    = rd_grant ? grant_data : rsrc_q;
        araddr_d  = rd_grant ? (grant_data ? bus.data_addr : bus.inst_addr) : araddr_q;
        arsize_d  = rd_grant ? (grant_data ? {1'b0, bus.data_size} : 3'd2) : arsize_q;
        aw_pend_d = w_accept | (aw_pend_q & ~bus.awready);
        w_pend_d  = w_accept | (w_pend_q & ~bus.wready);
        w_state_d = w_idle ? (w_accept ? W_SEND : W_IDLE) :
                    (w_state_q == W_SEND) ? ((aw_pend_d | w_pend_d) ? W_SEND : W_BRESP) :
                    (w_state_q == W_BRESP) ? (bus.bvalid ? W_IDLE : W_BRESP) : W_IDLE;
        awaddr_d  = w_accept ? bus.data_addr : awaddr_q;
        awsize_d  = w_accept ? {1'b0, bus.data_size} : awsize_q;
        wdata_d   = w_accept ? bus.data_wdata : wdata_q;
        wstrb_d   = w_accept ? bus.data_wstrb : wstrb_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rsrc_q    <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rsrc_q    <= rsrc_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    assign bus.inst_addr_ok = r_idle & inst_elig & ~grant_data;
    assign bus.data_addr_ok = (r_idle & grant_data) | w_accept;
    assign bus.inst_data_ok = r_done & ~rsrc_q;
    assign bus.data_data_ok = (r_done & rsrc_q) | (bus.bvalid & (w_state_q == W_BRESP));
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_rdata   = bus.rdata;
    assign bus.arid         = {3'b000, rsrc_q};
    assign bus.araddr       = araddr_q;
    assign bus.arsize       = arsize_q;
    assign bus.arvalid      = r_state_q == R_AR;
    assign bus.rready       = r_state_q == R_WAIT;
    assign bus.awaddr       = awaddr_q;
    assign bus.awsize       = awsize_q;
    assign bus.awvalid      = aw_pend_q;
    assign bus.wdata        = wdata_q;
    assign bus.wstrb        = wstrb_q;
    assign bus.wvalid       = w_pend_q;
    assign bus.bready       = w_state_q == W_BRESP;
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed test of cpu_axi_bridge with per-port response scoreboards.
// Arbitration expectations follow BRIDGE_DATA_PRIO_EN when the bench is built with it.
module tb_cpu_axi_bridge;
    typedef struct packed {
        logic        rd;
        logic [31:0] d;
    } dexp_t;

    logic clk, resetn;
    int checks = 0, errors = 0;
    logic [31:0] q_inst[$];
    dexp_t       q_data[$];
`ifdef BRIDGE_DATA_PRIO_EN
    localparam logic DATA_FIRST_AFTER_RESET = 1'b1;
`else
    localparam logic DATA_FIRST_AFTER_RESET = 1'b0;
`endif

    cpu_axi_bridge_if bus();
    cpu_axi_bridge dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic sb_check;
        logic [31:0] e;
        dexp_t       de;
        if (bus.inst_data_ok) begin
            chk("inst_ok_expected", q_inst.size() != 0, 1'b1);
            if (q_inst.size() != 0) begin
                e = q_inst.pop_front();
                chk("inst_rdata", bus.inst_rdata, e);
            end
        end
        if (bus.data_data_ok) begin
            chk("data_ok_expected", q_data.size() != 0, 1'b1);
            if (q_data.size() != 0) begin
                de = q_data.pop_front();
                if (de.rd) chk("data_rdata", bus.data_rdata, de.d);
            end
        end
    endtask

    // Called in the grant cycle; completes a minimum-latency read and returns one cycle after data_ok.
    task automatic read_txn(input logic src, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] rd);
        tick;
        if (src) bus.data_req = 1'b0;
        else     bus.inst_req = 1'b0;
        settle;
        chk("ar_valid", bus.arvalid, 1'b1);
        chk("ar_addr", bus.araddr, addr);
        chk("ar_id", bus.arid, {3'b000, src});
        chk("ar_size", bus.arsize, size);
        chk("ar_no_inst_ok", bus.inst_addr_ok, 1'b0);
        chk("ar_no_data_ok", bus.data_addr_ok, 1'b0);
        sb_check();
        bus.arready = 1'b1;
        tick;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = rd;
        bus.rid     = {3'b000, src};
        if (src) q_data.push_back('{1'b1, rd});
        else     q_inst.push_back(rd);
        settle;
        chk("r_arvalid_low", bus.arvalid, 1'b0);
        chk("r_ready", bus.rready, 1'b1);
        chk("r_data_ok", src ? bus.data_data_ok : bus.inst_data_ok, 1'b1);
        chk("r_no_inst_ok", bus.inst_addr_ok, 1'b0);
        sb_check();
        tick;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
    endtask

    task automatic contend(input logic data_first, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] ird, input logic [31:0] drd);
        bus.inst_req  = 1'b1;
        bus.inst_addr = ia;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = da;
        bus.data_size = 2'd2;
        settle;
        chk("arb_inst_ok", bus.inst_addr_ok, !data_first);
        chk("arb_data_ok", bus.data_addr_ok, data_first);
        read_txn(data_first, data_first ? da : ia, 3'd2, data_first ? drd : ird);
        settle;
        chk("arb_loser_inst_ok", bus.inst_addr_ok, data_first);
        chk("arb_loser_data_ok", bus.data_addr_ok, !data_first);
        read_txn(!data_first, data_first ? ia : da, 3'd2, data_first ? ird : drd);
    endtask

    initial begin
        resetn = 1'b0;
        bus.inst_req = 0; bus.inst_addr = 0; bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0;
        bus.data_addr = 0; bus.data_wdata = 0; bus.data_wstrb = 0; bus.arready = 0; bus.rid = 0;
        bus.rdata = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        tick;
        tick;
        settle;
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_wvalid", bus.wvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_bready", bus.bready, 1'b0);
        chk("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
        chk("rst_data_data_ok", bus.data_data_ok, 1'b0);
        chk("rst_araddr", bus.araddr, 32'h0);
        chk("rst_awaddr", bus.awaddr, 32'h0);
        chk("rst_wstrb", bus.wstrb, 4'h0);
        resetn = 1'b1;
        tick;

        // Single inst read at minimum latency.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_0000;
        settle;
        chk("t1_inst_addr_ok", bus.inst_addr_ok, 1'b1);
        chk("t1_data_addr_ok", bus.data_addr_ok, 1'b0);
        read_txn(1'b0, 32'h1C00_0000, 3'd2, 32'h0280_0C0C);

        // After an inst grant, data wins the next contention in both arbitration modes.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_0004;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = 32'h0000_0100;
        bus.data_size = 2'd2;
        settle;
        chk("t2_data_granted", bus.data_addr_ok, 1'b1);
        chk("t2_inst_held", bus.inst_addr_ok, 1'b0);
        read_txn(1'b1, 32'h0000_0100, 3'd2, 32'h1122_3344);
        contend(DATA_FIRST_AFTER_RESET, 32'h1C00_0004, 32'h0000_0100, 32'h99AA_BBCC, 32'h5566_7788);

        // Byte write with early wready and late awready; data read parked during W_BRESP.
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'h0000_0103;
        bus.data_wdata = 32'hAA00_0000;
        bus.data_wstrb = 4'b1000;
        settle;
        chk("t3_wr_addr_ok", bus.data_addr_ok, 1'b1);
        tick;
        bus.data_req = 1'b0;
        bus.data_wr  = 1'b0;
        bus.wready   = 1'b1;
        settle;
        chk("t3_awvalid_1", bus.awvalid, 1'b1);
        chk("t3_wvalid_1", bus.wvalid, 1'b1);
        chk("t3_awaddr", bus.awaddr, 32'h0000_0103);
        chk("t3_awsize", bus.awsize, 3'd0);
        chk("t3_wdata", bus.wdata, 32'hAA00_0000);
        chk("t3_wstrb", bus.wstrb, 4'b1000);
        tick;
        bus.wready = 1'b0;
        settle;
        chk("t3_wvalid_dropped", bus.wvalid, 1'b0);
        chk("t3_awvalid_2", bus.awvalid, 1'b1);
        tick;
        bus.awready = 1'b1;
        settle;
        chk("t3_awvalid_3", bus.awvalid, 1'b1);
        chk("t3_no_bready", bus.bready, 1'b0);
        tick;
        bus.awready   = 1'b0;
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0200;
        bus.data_size = 2'd2;
        settle;
        chk("t3_awvalid_dropped", bus.awvalid, 1'b0);
        chk("t3_bready", bus.bready, 1'b1);
        chk("t4_rd_blocked_1", bus.data_addr_ok, 1'b0);
        chk("t3_no_early_ok", bus.data_data_ok, 1'b0);
        tick;
        bus.bvalid = 1'b1;
        q_data.push_back('{1'b0, 32'h0});
        settle;
        chk("t3_wr_data_ok", bus.data_data_ok, 1'b1);
        chk("t4_rd_blocked_2", bus.data_addr_ok, 1'b0);
        sb_check();
        tick;
        bus.bvalid = 1'b0;
        settle;
        chk("t3_bready_low", bus.bready, 1'b0);
        chk("t4_rd_granted", bus.data_addr_ok, 1'b1);
        read_txn(1'b1, 32'h0000_0200, 3'd2, 32'hCAFE_F00D);

        // Inst read overlapping a word write; both responses land in the same cycle.
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd2;
        bus.data_addr  = 32'h0000_0040;
        bus.data_wdata = 32'h1234_5678;
        bus.data_wstrb = 4'hF;
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h1C00_0008;
        settle;
        chk("t5_inst_addr_ok", bus.inst_addr_ok, 1'b1);
        chk("t5_data_addr_ok", bus.data_addr_ok, 1'b1);
        tick;
        bus.data_req = 1'b0;
        bus.data_wr  = 1'b0;
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        bus.awready  = 1'b1;
        bus.wready   = 1'b1;
        settle;
        chk("t5_arvalid", bus.arvalid, 1'b1);
        chk("t5_awvalid", bus.awvalid, 1'b1);
        chk("t5_wvalid", bus.wvalid, 1'b1);
        tick;
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h55AA_55AA;
        bus.rid     = 4'd0;
        bus.bvalid  = 1'b1;
        q_inst.push_back(32'h55AA_55AA);
        q_data.push_back('{1'b0, 32'h0});
        settle;
        chk("t5_inst_data_ok", bus.inst_data_ok, 1'b1);
        chk("t5_data_data_ok", bus.data_data_ok, 1'b1);
        sb_check();
        tick;
        bus.rvalid = 1'b0;
        bus.bvalid = 1'b0;
        settle;
        chk("t5_inst_ok_low", bus.inst_data_ok, 1'b0);
        chk("t5_data_ok_low", bus.data_data_ok, 1'b0);
        chk("t5_rready_low", bus.rready, 1'b0);

        // Reset in R_AR aborts the read; a stale rvalid afterwards is ignored.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_000C;
        settle;
        chk("t6_inst_addr_ok", bus.inst_addr_ok, 1'b1);
        tick;
        bus.inst_req = 1'b0;
        settle;
        chk("t6_arvalid", bus.arvalid, 1'b1);
        resetn = 1'b0;
        settle;
        chk("t6_arvalid_async_clr", bus.arvalid, 1'b0);
        chk("t6_araddr_clr", bus.araddr, 32'h0);
        tick;
        resetn = 1'b1;
        tick;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_BAD0;
        settle;
        chk("t6_no_rready", bus.rready, 1'b0);
        chk("t6_no_inst_ok", bus.inst_data_ok, 1'b0);
        sb_check();
        tick;
        bus.rvalid = 1'b0;
        contend(DATA_FIRST_AFTER_RESET, 32'h1C00_0010, 32'h0000_0300, 32'h0BAD_CAFE, 32'hFEED_BEEF);

        chk("q_inst_drained", q_inst.size(), 32'd0);
        chk("q_data_drained", q_data.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
